// File: rtl/ddr2_local_arbiter.sv
// Two-master round-robin arbiter for the DDR2 controller local port.
// An in-order tag FIFO remembers the owner of each accepted read so returned beats are steered back.
module ddr2_local_arbiter #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 128,
  parameter int TAG_DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // controller side
  input  logic                      s_init_done,
  output logic [ADDR_WIDTH-1:0]     s_address,
  output logic                      s_burstbegin,
  input  logic                      s_ready,
  output logic                      s_read_req,
  output logic                      s_write_req,
  output logic [DATA_WIDTH-1:0]     s_wdata,
  input  logic [DATA_WIDTH-1:0]     s_rdata,
  input  logic                      s_rdata_valid,
  // master 0
  output logic                      m0_init_done,
  input  logic [ADDR_WIDTH-1:0]     m0_address,
  input  logic                      m0_burstbegin,
  input  logic                      m0_read_req,
  input  logic                      m0_write_req,
  input  logic [DATA_WIDTH-1:0]     m0_wdata,
  output logic                      m0_ready,
  output logic [DATA_WIDTH-1:0]     m0_rdata,
  output logic                      m0_rdata_valid,
  // master 1
  output logic                      m1_init_done,
  input  logic [ADDR_WIDTH-1:0]     m1_address,
  input  logic                      m1_burstbegin,
  input  logic                      m1_read_req,
  input  logic                      m1_write_req,
  input  logic [DATA_WIDTH-1:0]     m1_wdata,
  output logic                      m1_ready,
  output logic [DATA_WIDTH-1:0]     m1_rdata,
  output logic                      m1_rdata_valid,
  // status
  output logic [$clog2(TAG_DEPTH):0] rd_outstanding,
  output logic                      err_unexpected_rdata
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam logic [PW:0] C_FULL = (PW+1)'(TAG_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                 r_last;
  logic [TAG_DEPTH-1:0] r_tag;
  logic [PW-1:0]        r_wptr;
  logic [PW-1:0]        r_rptr;
  logic [PW:0]          r_count;
  logic                 r_err;

  logic w_m0_req;
  logic w_m1_req;
  logic w_own_rd;
  logic w_own_wr;
  logic w_own_bb;
  logic w_owner;
  logic w_full;
  logic w_empty;
  logic w_blocked;
  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_head;

  assign w_m0_req = m0_read_req | m0_write_req;
  assign w_m1_req = m1_read_req | m1_write_req;
  assign w_full   = (r_count == C_FULL);
  assign w_empty  = (r_count == '0);
  assign w_head   = r_tag[r_rptr];

  // Owner mux onto the controller port; blocking uses pre-pop occupancy.
  always_comb begin
    s_address    = '0;
    s_wdata      = '0;
    s_burstbegin = 1'b0;
    s_read_req   = 1'b0;
    s_write_req  = 1'b0;
    w_own_rd     = 1'b0;
    w_own_wr     = 1'b0;
    w_own_bb     = 1'b0;
    w_owner      = 1'b0;
    w_blocked    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      OWN0: begin
        s_address = m0_address;
        s_wdata   = m0_wdata;
        w_own_rd  = m0_read_req;
        w_own_wr  = m0_write_req;
        w_own_bb  = m0_burstbegin;
        w_owner   = 1'b0;
      end
      OWN1: begin
        s_address = m1_address;
        s_wdata   = m1_wdata;
        w_own_rd  = m1_read_req;
        w_own_wr  = m1_write_req;
        w_own_bb  = m1_burstbegin;
        w_owner   = 1'b1;
      end
      default: ;
    endcase
    w_blocked    = w_own_rd & w_full;
    s_read_req   = w_own_rd & ~w_full;
    s_write_req  = w_own_wr;
    s_burstbegin = w_own_bb & ~w_blocked;
    w_accept     = (w_own_rd | w_own_wr) & s_ready & ~w_blocked;
  end

  assign m0_ready = (r_state == OWN0) & w_accept;
  assign m1_ready = (r_state == OWN1) & w_accept;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (s_init_done) begin
          if (w_m0_req && w_m1_req) w_state_nxt = r_last ? OWN0 : OWN1;
          else if (w_m0_req)        w_state_nxt = OWN0;
          else if (w_m1_req)        w_state_nxt = OWN1;
        end
      end
      OWN0: begin
        if (w_accept)       w_state_nxt = w_m1_req ? OWN1 : OWN0;
        else if (!w_m0_req) w_state_nxt = w_m1_req ? OWN1 : IDLE;
      end
      OWN1: begin
        if (w_accept)       w_state_nxt = w_m0_req ? OWN0 : OWN1;
        else if (!w_m1_req) w_state_nxt = w_m0_req ? OWN0 : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_last <= w_owner;
    end
  end

  assign w_push = w_accept & w_own_rd;
  assign w_pop  = s_rdata_valid & ~w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) begin
        r_tag[r_wptr] <= w_owner;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      if (s_rdata_valid && w_empty) r_err <= 1'b1;
    end
  end

  assign rd_outstanding       = r_count;
  assign err_unexpected_rdata = r_err;

  assign m0_init_done   = s_init_done;
  assign m1_init_done   = s_init_done;
  assign m0_rdata       = s_rdata;
  assign m1_rdata       = s_rdata;
  assign m0_rdata_valid = w_pop & ~w_head;
  assign m1_rdata_valid = w_pop & w_head;

endmodule

// File: tb/tb_ddr2_local_arbiter.sv
// Scoreboard bench for ddr2_local_arbiter: grants, tag FIFO routing, blocking, error and reset.
module tb_ddr2_local_arbiter;

  localparam int AW = 26;
  localparam int DW = 128;
  localparam int TD = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_init_done;
  logic [AW-1:0] s_address;
  logic          s_burstbegin;
  logic          s_ready;
  logic          s_read_req;
  logic          s_write_req;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata;
  logic          s_rdata_valid;
  logic          m0_init_done, m1_init_done;
  logic [AW-1:0] m0_address, m1_address;
  logic          m0_burstbegin, m1_burstbegin;
  logic          m0_read_req, m1_read_req;
  logic          m0_write_req, m1_write_req;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_ready, m1_ready;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_rdata_valid, m1_rdata_valid;
  logic [3:0]    rd_outstanding;
  logic          err_unexpected_rdata;

  int n_err = 0;
  int n_chk = 0;
  int exp_last = 1;

  logic [AW-1:0] addr_q[$];
  int            grant_q[$];
  int            tag_q[$];

  ddr2_local_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_init_done(s_init_done), .s_address(s_address), .s_burstbegin(s_burstbegin),
    .s_ready(s_ready), .s_read_req(s_read_req), .s_write_req(s_write_req),
    .s_wdata(s_wdata), .s_rdata(s_rdata), .s_rdata_valid(s_rdata_valid),
    .m0_init_done(m0_init_done), .m0_address(m0_address), .m0_burstbegin(m0_burstbegin),
    .m0_read_req(m0_read_req), .m0_write_req(m0_write_req), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_rdata_valid(m0_rdata_valid),
    .m1_init_done(m1_init_done), .m1_address(m1_address), .m1_burstbegin(m1_burstbegin),
    .m1_read_req(m1_read_req), .m1_write_req(m1_write_req), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_rdata_valid(m1_rdata_valid),
    .rd_outstanding(rd_outstanding), .err_unexpected_rdata(err_unexpected_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0; s_init_done = 1'b0; s_ready = 1'b1;
    s_rdata = '0; s_rdata_valid = 1'b0;
    m0_address = '0; m0_burstbegin = 1'b0; m0_read_req = 1'b0; m0_write_req = 1'b0; m0_wdata = '0;
    m1_address = '0; m1_burstbegin = 1'b0; m1_read_req = 1'b0; m1_write_req = 1'b0; m1_wdata = '0;
    #1;
    n_chk++; if (rd_outstanding !== 4'd0) begin n_err++; $display("FAIL reset_occ: got %0d want 0", rd_outstanding); end
    n_chk++; if (err_unexpected_rdata !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err_unexpected_rdata); end
    n_chk++; if ({s_read_req, s_write_req, s_burstbegin, m0_ready, m1_ready, m0_rdata_valid, m1_rdata_valid} !== 7'b0)
      begin n_err++; $display("FAIL reset_outs: got %b want 0000000",
        {s_read_req, s_write_req, s_burstbegin, m0_ready, m1_ready, m0_rdata_valid, m1_rdata_valid}); end
    n_chk++; if (s_address !== '0) begin n_err++; $display("FAIL reset_addr: got %h want 0", s_address); end
    n_chk++; if (m0_init_done !== 1'b0) begin n_err++; $display("FAIL init_copy0: got %b want 0", m0_init_done); end
    s_init_done = 1'b1; #1;
    n_chk++; if (m1_init_done !== 1'b1) begin n_err++; $display("FAIL init_copy1: got %b want 1", m1_init_done); end
    @(negedge clk); rst_n = 1'b1;
    exp_last = 1;
  endtask

  task automatic test_single_master();
    @(negedge clk);
    m0_address = 26'h100; m0_wdata = 128'hA000; m0_write_req = 1'b1; #1;
    n_chk++; if (m0_ready !== 1'b0 || s_write_req !== 1'b0) begin n_err++;
      $display("FAIL single_bubble: ready=%b wreq=%b want 0 0", m0_ready, s_write_req); end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      m0_address = 26'h100 + AW'(i); m0_wdata = 128'hA000 + DW'(i);
      addr_q.push_back(26'h100 + AW'(i));
      #1;
      n_chk++; if (m0_ready !== 1'b1 || m1_ready !== 1'b0 || s_write_req !== 1'b1) begin n_err++;
        $display("FAIL single_ready[%0d]: m0=%b m1=%b wreq=%b want 1 0 1", i, m0_ready, m1_ready, s_write_req); end
      begin
        logic [AW-1:0] ea;
        ea = addr_q.pop_front();
        n_chk++; if (s_address !== ea) begin n_err++; $display("FAIL single_addr[%0d]: got %h want %h", i, s_address, ea); end
      end
      n_chk++; if (s_wdata !== 128'hA000 + DW'(i)) begin n_err++; $display("FAIL single_wdata[%0d]: got %h", i, s_wdata); end
    end
    exp_last = 0;
    @(negedge clk); m0_write_req = 1'b0; #1;
    n_chk++; if (s_write_req !== 1'b0 || m0_ready !== 1'b0) begin n_err++;
      $display("FAIL single_release: wreq=%b ready=%b want 0 0", s_write_req, m0_ready); end
    @(negedge clk);
  endtask

  task automatic test_contention();
    int nxt;
    nxt = (exp_last == 0) ? 1 : 0;
    for (int i = 0; i < 8; i++) begin grant_q.push_back(nxt); nxt = 1 - nxt; end
    @(negedge clk);
    m0_address = 26'h200; m1_address = 26'h300;
    m0_write_req = 1'b1; m1_write_req = 1'b1; #1;
    n_chk++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin n_err++;
      $display("FAIL cont_bubble: m0=%b m1=%b want 0 0", m0_ready, m1_ready); end
    for (int i = 0; i < 8; i++) begin
      int g;
      @(negedge clk); #1;
      g = grant_q.pop_front();
      n_chk++; if (m0_ready !== (g == 0) || m1_ready !== (g == 1)) begin n_err++;
        $display("FAIL cont_grant[%0d]: m0=%b m1=%b want owner %0d", i, m0_ready, m1_ready, g); end
      n_chk++; if (s_address !== ((g == 0) ? m0_address : m1_address)) begin n_err++;
        $display("FAIL cont_addr[%0d]: got %h want owner %0d address", i, s_address, g); end
      exp_last = g;
      if (g == 0) m0_address = m0_address + 1'b1; else m1_address = m1_address + 1'b1;
    end
    @(negedge clk); m0_write_req = 1'b0; m1_write_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tag_full();
    @(negedge clk);
    m0_address = 26'h400; m0_read_req = 1'b1;
    for (int i = 0; i < TD; i++) begin
      @(negedge clk); #1;
      n_chk++; if (m0_ready !== 1'b1 || s_read_req !== 1'b1) begin n_err++;
        $display("FAIL full_fill[%0d]: ready=%b rreq=%b want 1 1", i, m0_ready, s_read_req); end
      tag_q.push_back(0);
    end
    exp_last = 0;
    @(negedge clk); #1;
    n_chk++; if (s_read_req !== 1'b0 || m0_ready !== 1'b0) begin n_err++;
      $display("FAIL full_block: rreq=%b ready=%b want 0 0", s_read_req, m0_ready); end
    n_chk++; if (rd_outstanding !== 4'd8) begin n_err++; $display("FAIL full_occ: got %0d want 8", rd_outstanding); end
    @(negedge clk); s_rdata_valid = 1'b1; s_rdata = 128'h55; #1;
    begin
      int t;
      t = tag_q.pop_front();
      n_chk++; if (m0_rdata_valid !== (t == 0) || m1_rdata_valid !== (t == 1)) begin n_err++;
        $display("FAIL full_ret_route: v0=%b v1=%b want owner %0d", m0_rdata_valid, m1_rdata_valid, t); end
    end
    n_chk++; if (s_read_req !== 1'b0) begin n_err++; $display("FAIL full_prepop: rreq=%b want 0", s_read_req); end
    @(negedge clk); s_rdata_valid = 1'b0; #1;
    n_chk++; if (rd_outstanding !== 4'd7) begin n_err++; $display("FAIL full_occ7: got %0d want 7", rd_outstanding); end
    n_chk++; if (s_read_req !== 1'b1 || m0_ready !== 1'b1) begin n_err++;
      $display("FAIL full_unblock: rreq=%b ready=%b want 1 1", s_read_req, m0_ready); end
    tag_q.push_back(0);
    @(negedge clk); m0_read_req = 1'b0; #1;
    n_chk++; if (rd_outstanding !== 4'd8) begin n_err++; $display("FAIL full_refill: got %0d want 8", rd_outstanding); end
    for (int i = 0; i < TD; i++) begin
      int t;
      @(negedge clk); s_rdata_valid = 1'b1; s_rdata = DW'(i); #1;
      t = tag_q.pop_front();
      n_chk++; if (m0_rdata_valid !== (t == 0) || m1_rdata_valid !== (t == 1)) begin n_err++;
        $display("FAIL drain_route[%0d]: v0=%b v1=%b want owner %0d", i, m0_rdata_valid, m1_rdata_valid, t); end
    end
    @(negedge clk); s_rdata_valid = 1'b0; #1;
    n_chk++; if (rd_outstanding !== 4'd0) begin n_err++; $display("FAIL drain_occ: got %0d want 0", rd_outstanding); end
  endtask

  task automatic issue_read(input int id, input logic [AW-1:0] addr);
    bit got;
    got = 1'b0;
    @(negedge clk);
    if (id == 0) begin m0_address = addr; m0_read_req = 1'b1; end
    else         begin m1_address = addr; m1_read_req = 1'b1; end
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      if ((id == 0 && m0_ready === 1'b1) || (id == 1 && m1_ready === 1'b1)) got = 1'b1;
      else @(negedge clk);
    end
    n_chk++; if (!got) begin n_err++; $display("FAIL read_grant_timeout: master %0d got no ready want ready", id); end
    if (got) begin tag_q.push_back(id); exp_last = id; end
    @(negedge clk);
    m0_read_req = 1'b0; m1_read_req = 1'b0;
  endtask

  task automatic test_routing();
    issue_read(0, 26'h10);
    issue_read(1, 26'h20);
    issue_read(1, 26'h30);
    issue_read(0, 26'h40);
    @(negedge clk); #1;
    n_chk++; if (rd_outstanding !== 4'd4) begin n_err++; $display("FAIL route_occ: got %0d want 4", rd_outstanding); end
    for (int i = 0; i < 4; i++) begin
      int t;
      @(negedge clk); s_rdata_valid = 1'b1; s_rdata = DW'(i + 1); #1;
      t = tag_q.pop_front();
      n_chk++; if (m0_rdata_valid !== (t == 0) || m1_rdata_valid !== (t == 1)) begin n_err++;
        $display("FAIL route_valid[%0d]: v0=%b v1=%b want owner %0d", i, m0_rdata_valid, m1_rdata_valid, t); end
      n_chk++; if (m0_rdata !== DW'(i + 1) || m1_rdata !== DW'(i + 1)) begin n_err++;
        $display("FAIL route_data[%0d]: d0=%h d1=%h want %0d", i, m0_rdata, m1_rdata, i + 1); end
    end
    @(negedge clk); s_rdata_valid = 1'b0;
  endtask

  task automatic test_error_reset();
    @(negedge clk); s_rdata_valid = 1'b1; s_rdata = 128'hDEAD; #1;
    n_chk++; if (m0_rdata_valid !== 1'b0 || m1_rdata_valid !== 1'b0) begin n_err++;
      $display("FAIL stray_valid: v0=%b v1=%b want 0 0", m0_rdata_valid, m1_rdata_valid); end
    @(negedge clk); s_rdata_valid = 1'b0; #1;
    n_chk++; if (err_unexpected_rdata !== 1'b1) begin n_err++; $display("FAIL err_set: got %b want 1", err_unexpected_rdata); end
    repeat (3) @(negedge clk);
    #1;
    n_chk++; if (err_unexpected_rdata !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", err_unexpected_rdata); end
    issue_read(0, 26'h50);
    issue_read(1, 26'h60);
    issue_read(0, 26'h70);
    @(negedge clk); #1;
    n_chk++; if (rd_outstanding !== 4'd3) begin n_err++; $display("FAIL pre_reset_occ: got %0d want 3", rd_outstanding); end
    @(negedge clk); m1_write_req = 1'b1; rst_n = 1'b0; #1;
    n_chk++; if (rd_outstanding !== 4'd0 || err_unexpected_rdata !== 1'b0) begin n_err++;
      $display("FAIL async_reset: occ=%0d err=%b want 0 0", rd_outstanding, err_unexpected_rdata); end
    n_chk++; if (s_write_req !== 1'b0 || m1_ready !== 1'b0) begin n_err++;
      $display("FAIL reset_idle: wreq=%b ready=%b want 0 0", s_write_req, m1_ready); end
    tag_q.delete();
    exp_last = 1;
    @(negedge clk); rst_n = 1'b1; m1_write_req = 1'b0; s_rdata_valid = 1'b1; #1;
    n_chk++; if (m0_rdata_valid !== 1'b0 || m1_rdata_valid !== 1'b0) begin n_err++;
      $display("FAIL discard_valid: v0=%b v1=%b want 0 0", m0_rdata_valid, m1_rdata_valid); end
    @(negedge clk); s_rdata_valid = 1'b0; #1;
    n_chk++; if (err_unexpected_rdata !== 1'b1) begin n_err++; $display("FAIL discard_err: got %b want 1", err_unexpected_rdata); end
    m0_write_req = 1'b1; m1_write_req = 1'b1; #1;
    n_chk++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin n_err++;
      $display("FAIL tie_bubble: m0=%b m1=%b want 0 0", m0_ready, m1_ready); end
    @(negedge clk); #1;
    n_chk++; if (m0_ready !== (exp_last == 1) || m1_ready !== (exp_last == 0)) begin n_err++;
      $display("FAIL first_tie: m0=%b m1=%b want m0 granted", m0_ready, m1_ready); end
    exp_last = 0;
    @(negedge clk); m0_write_req = 1'b0; m1_write_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_init_gating();
    @(negedge clk);
    s_init_done = 1'b0; m1_address = 26'h3AB; m1_write_req = 1'b1;
    addr_q.push_back(26'h3AB);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_chk++; if (s_write_req !== 1'b0 || m1_ready !== 1'b0 || m1_init_done !== 1'b0) begin n_err++;
        $display("FAIL init_hold[%0d]: wreq=%b ready=%b done=%b want 0 0 0", i, s_write_req, m1_ready, m1_init_done); end
    end
    @(negedge clk); s_init_done = 1'b1; #1;
    n_chk++; if (s_write_req !== 1'b0) begin n_err++; $display("FAIL init_edge: wreq=%b want 0", s_write_req); end
    @(negedge clk); #1;
    n_chk++; if (s_write_req !== 1'b1 || m1_ready !== 1'b1) begin n_err++;
      $display("FAIL init_own1: wreq=%b ready=%b want 1 1", s_write_req, m1_ready); end
    begin
      logic [AW-1:0] ea;
      ea = addr_q.pop_front();
      n_chk++; if (s_address !== ea) begin n_err++; $display("FAIL init_addr: got %h want %h", s_address, ea); end
    end
    @(negedge clk); m1_write_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_master();
    test_contention();
    test_tag_full();
    test_routing();
    test_error_reset();
    test_init_gating();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ddr2_local_arbiter.md
# ddr2_local_arbiter

Two-master arbiter for the DDR2 controller local interface. It sits between two local-interface traffic sources (for example the memory test generator and a second requester) and the single local port of the DDR2 controller. It grants one master at a time with round-robin fairness and forwards that master's single-beat read/write requests. It records the owner of every accepted read in an in-order tag FIFO so that each returned read beat goes back to the master that issued it.

## Interface
Parameters:
- ADDR_WIDTH, 26, local address width
- DATA_WIDTH, 128, local data width
- TAG_DEPTH, 8, maximum outstanding reads; must be a power of 2, at least 2

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_init_done  in  1  controller calibration done
- s_address  out  ADDR_WIDTH  address to controller
- s_burstbegin  out  1  burst begin to controller
- s_ready  in  1  controller accepts the current request
- s_read_req  out  1  read request
- s_write_req  out  1  write request
- s_wdata  out  DATA_WIDTH  write data
- s_rdata  in  DATA_WIDTH  read data
- s_rdata_valid  in  1  read beat valid
- mN_init_done  out  1  copy of s_init_done (N = 0, 1)
- mN_address  in  ADDR_WIDTH  master address
- mN_burstbegin  in  1  master burst begin
- mN_read_req, mN_write_req  in  1 each  master requests; never both high together
- mN_wdata  in  DATA_WIDTH  master write data
- mN_ready  out  1  request from master N accepted this cycle
- mN_rdata  out  DATA_WIDTH  s_rdata, broadcast to both masters
- mN_rdata_valid  out  1  beat belongs to master N
- rd_outstanding  out  log2(TAG_DEPTH)+1  current tag FIFO occupancy
- err_unexpected_rdata  out  1  sticky; set on s_rdata_valid with an empty tag FIFO

## Operation
- FSM states: IDLE, OWN0, OWN1. The state is registered. The owned master's address, burstbegin, wdata and req signals are muxed combinationally to s_*. In IDLE, s_read_req, s_write_req and s_burstbegin are 0, and s_address and s_wdata are 0.
- IDLE: holds while s_init_done = 0. Otherwise:
  - If exactly one master requests (read or write), go to that master's OWN state.
  - If both request, go to the master that is not `last`.
- Blocked: the owner is requesting a read and rd_outstanding == TAG_DEPTH. While blocked, s_read_req is forced to 0. Writes are never blocked.
- Accept: the owner requests, s_ready = 1, and the request is not blocked. On accept, mN_ready = s_ready for the owner, and `last` <= owner. mN_ready is 0 for the non-owner and 0 in IDLE.
- OWNx transitions:
  - On accept with the other master requesting: go to OWN(other).
  - On accept with the other master idle: stay in OWNx, giving back-to-back streaming with no bubble.
  - Owner not requesting: go to OWN(other) if the other master requests, else IDLE.
  - Otherwise: hold.
- Tag FIFO:
  - Push owner id on every accepted read.
  - Pop on s_rdata_valid when not empty.
  - Simultaneous push and pop leaves occupancy unchanged.
  - The full check uses the pre-pop occupancy, so a read is blocked at full even if a pop happens in the same cycle.
- Read routing: mN_rdata_valid = s_rdata_valid and (FIFO not empty) and (head == N). Routing is combinational.
- Unexpected data: on s_rdata_valid with an empty FIFO, both mN_rdata_valid are 0 and err_unexpected_rdata is set until reset.
- s_init_done low mid-operation: the FSM finishes the current OWN state normally and only blocks the IDLE exit. Outstanding tags are kept.

## Timing
- Reset values:
  - State IDLE; `last` = 1, so m0 wins the first tie.
  - rd_outstanding 0; err_unexpected_rdata 0.
  - All s_* requests and mN_ready/rdata_valid 0; mN_init_done follows s_init_done.
- Arbitration bubble: 1 cycle from IDLE (request seen -> OWN next cycle). There is no bubble on an owner-to-owner handover.
- Request path s_* <- mN_*: combinational, 0 cycles.
- Read return path: 0 cycles.
- Occupancy: rd_outstanding updates the cycle after a push or pop.
- Masters must hold address, wdata and req stable until mN_ready.
- Reset asserted mid-operation: all state returns to reset values at once. In-flight tags are discarded, and subsequent stray beats set err.

## Test plan
- Single master: m0 holds write_req for 16 writes with s_ready = 1 -> OWN0 entered 1 cycle after the request, 16 consecutive m0_ready pulses, s_address equals m0_address each cycle, m1_ready = 0 throughout.
- Contention: m0 and m1 both hold write_req, s_ready = 1 -> grants alternate m0, m1, m0, m1 with no idle cycle between grants.
- Tag full: m0 issues 8 reads with s_rdata_valid held 0 (TAG_DEPTH = 8) -> the 9th read is blocked (s_read_req = 0), rd_outstanding = 8. A single return beat -> rd_outstanding = 7; the blocked read is accepted the next cycle.
- Routing: read order m0, m1, m1, m0; return 4 beats with data 0x1 to 0x4 -> m0 receives 0x1 and 0x4, m1 receives 0x2 and 0x3, never both valid in one cycle.
- Error and reset: a beat with an empty FIFO -> no mN_rdata_valid, err = 1, staying 1. Assert rst_n with 3 reads outstanding -> rd_outstanding = 0, err = 0, state IDLE.
- Init gating: s_init_done = 0 with m1 requesting -> stays IDLE and s_write_req = 0. Raise s_init_done -> OWN1 on the following cycle.
